// File: rtl/wu_radio_pkg.sv
// Shared types and constants for the wake-up radio packet transmitter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package wu_radio_pkg;

    // Default widths: maximum signature length and timer width.
    localparam int WU_SIG_W = 32;
    localparam int WU_CNT_W = 32;

    // Lower bounds applied when the configuration is captured.
    localparam int MIN_BIT_PERIOD = 2;
    localparam int MIN_REPEATS    = 1;

    // Packet sequencer states.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PREAMBLE = 2'd1,
        PAYLOAD  = 2'd2,
        GAP      = 2'd3
    } wu_state_e;

endpackage

// File: rtl/wu_bit_timer.sv
// Loadable down-counter; tick_o is high while the count is zero.
// Latency: a load of N gives tick_o N cycles after the load edge (N+1 cycles per period).
// Backpressure: none; load_i always wins over counting.
module wu_bit_timer
    import wu_radio_pkg::*;
#(
    parameter int CNT_W = WU_CNT_W
) (
    input  logic             clki,
    input  logic             reset_n,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             tick_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Reload on request, otherwise count down and park at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clki or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = (cnt_q == '0);

endmodule

// File: rtl/wu_pkt_tx.sv
// OOK wake-up packet serialiser (preamble + MSB-first signature, repeats, gaps); Manchester payload when WU_TX_MANCHESTER_EN is defined.
// Latency: first bit on mod_out one cycle after start is sampled; all outputs registered.
// Backpressure: none; start is ignored while busy, abort returns to IDLE on the next cycle.
module wu_pkt_tx
    import wu_radio_pkg::*;
#(
    parameter int SIG_W = WU_SIG_W,
    parameter int CNT_W = WU_CNT_W
) (
    input  logic             clki,
    input  logic             reset_n,
    input  logic             start,
    input  logic             abort,
    input  logic [SIG_W-1:0] signature,
    input  logic [5:0]       sig_len,
    input  logic [CNT_W-1:0] bit_period,
    input  logic [7:0]       preamble_len,
    input  logic [CNT_W-1:0] gap,
    input  logic [15:0]      repeats,
    output logic             mod_out,
    output logic             pkt_strobe,
    output logic             busy,
    output logic             done,
    output logic [15:0]      pkts_sent
);

    localparam int IDX_W = (SIG_W > 1) ? $clog2(SIG_W) : 1;

    // Sequencer state and output registers.
    wu_state_e        state_q, state_d;
    logic [7:0]       idx_q, idx_d;
    logic             mod_q, mod_d;
    logic             strobe_q, strobe_d;
    logic             done_q, done_d;
    logic [15:0]      pkts_q, pkts_d;
    logic [15:0]      pkts_inc;

    // Shadow copy of the (clamped) configuration, frozen for the whole request.
    logic [SIG_W-1:0] sig_q, sig_d;
    logic [7:0]       len_q, len_d;
    logic [CNT_W-1:0] bp_q, bp_d;
    logic [7:0]       pre_q, pre_d;
    logic [CNT_W-1:0] gap_q, gap_d;
    logic [15:0]      reps_q, reps_d;

`ifdef WU_TX_MANCHESTER_EN
    // Second half of the current Manchester payload symbol.
    logic             half_q, half_d;
`endif

    // Clamped view of the live configuration inputs.
    logic [CNT_W-1:0] bp_in;
    logic [7:0]       len_in;
    logic [15:0]      reps_in;

    // Configuration used when a packet is launched: live inputs in IDLE, shadow otherwise.
    logic [SIG_W-1:0] sel_sig;
    logic [7:0]       sel_len;
    logic [CNT_W-1:0] sel_bp;
    logic [7:0]       sel_pre;

    logic             launch;
    logic             tmr_load;
    logic [CNT_W-1:0] tmr_val;
    logic             tmr_tick;

    // Reload value for one payload symbol: a full bit (NRZ) or a half-bit (Manchester).
    function automatic logic [CNT_W-1:0] sym_reload(input logic [CNT_W-1:0] bp);
`ifdef WU_TX_MANCHESTER_EN
        return (bp >> 1) - CNT_W'(1);
`else
        return bp - CNT_W'(1);
`endif
    endfunction

    // Clamp the incoming configuration so the sequencer never sees degenerate values.
    always_comb begin
`ifdef WU_TX_MANCHESTER_EN
        bp_in = bit_period & ~CNT_W'(1);
`else
        bp_in = bit_period;
`endif
        if (bp_in < CNT_W'(MIN_BIT_PERIOD)) begin
            bp_in = CNT_W'(MIN_BIT_PERIOD);
        end
        len_in = {2'b00, sig_len};
        if (len_in == 8'd0) begin
            len_in = 8'd1;
        end else if (len_in > 8'(SIG_W)) begin
            len_in = 8'(SIG_W);
        end
        reps_in = (repeats < 16'(MIN_REPEATS)) ? 16'(MIN_REPEATS) : repeats;
    end

    assign sel_sig  = (state_q == IDLE) ? signature    : sig_q;
    assign sel_len  = (state_q == IDLE) ? len_in       : len_q;
    assign sel_bp   = (state_q == IDLE) ? bp_in        : bp_q;
    assign sel_pre  = (state_q == IDLE) ? preamble_len : pre_q;
    assign pkts_inc = (pkts_q == 16'hFFFF) ? pkts_q : pkts_q + 16'd1;

    // Next-state, datapath and output decode for the packet sequencer.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        mod_d    = mod_q;
        strobe_d = 1'b0;
        done_d   = 1'b0;
        pkts_d   = pkts_q;
        sig_d    = sig_q;
        len_d    = len_q;
        bp_d     = bp_q;
        pre_d    = pre_q;
        gap_d    = gap_q;
        reps_d   = reps_q;
`ifdef WU_TX_MANCHESTER_EN
        half_d   = half_q;
`endif
        tmr_load = 1'b0;
        tmr_val  = '0;
        launch   = 1'b0;

        if (abort) begin
            // Abort beats everything, including a start seen in IDLE; the count is kept.
            state_d = IDLE;
            mod_d   = 1'b0;
            idx_d   = 8'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        sig_d  = signature;
                        len_d  = len_in;
                        bp_d   = bp_in;
                        pre_d  = preamble_len;
                        gap_d  = gap;
                        reps_d = reps_in;
                        pkts_d = 16'd0;
                        launch = 1'b1;
                    end
                end
                PREAMBLE: begin
                    if (tmr_tick) begin
                        tmr_load = 1'b1;
                        if (idx_q == pre_q - 8'd1) begin
                            state_d = PAYLOAD;
                            idx_d   = len_q - 8'd1;
                            mod_d   = sig_q[idx_d[IDX_W-1:0]];
                            tmr_val = sym_reload(bp_q);
`ifdef WU_TX_MANCHESTER_EN
                            half_d  = 1'b0;
`endif
                        end else begin
                            idx_d   = idx_q + 8'd1;
                            mod_d   = ~mod_q;
                            tmr_val = bp_q - CNT_W'(1);
                        end
                    end
                end
                PAYLOAD: begin
                    if (tmr_tick) begin
`ifdef WU_TX_MANCHESTER_EN
                        if (!half_q) begin
                            // Mid-bit transition: second half is the complement.
                            half_d   = 1'b1;
                            mod_d    = ~mod_q;
                            tmr_load = 1'b1;
                            tmr_val  = sym_reload(bp_q);
                        end else
`endif
                        if (idx_q != 8'd0) begin
                            idx_d    = idx_q - 8'd1;
                            mod_d    = sig_q[idx_d[IDX_W-1:0]];
                            tmr_load = 1'b1;
                            tmr_val  = sym_reload(bp_q);
`ifdef WU_TX_MANCHESTER_EN
                            half_d   = 1'b0;
`endif
                        end else begin
                            // End of the last payload bit: count the packet.
                            pkts_d = pkts_inc;
                            if (pkts_inc == reps_q) begin
                                state_d = IDLE;
                                mod_d   = 1'b0;
                                done_d  = 1'b1;
                            end else if (gap_q == '0) begin
                                launch = 1'b1;
                            end else begin
                                state_d  = GAP;
                                mod_d    = 1'b0;
                                tmr_load = 1'b1;
                                tmr_val  = gap_q - CNT_W'(1);
                            end
                        end
                    end
                end
                GAP: begin
                    if (tmr_tick) begin
                        launch = 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    mod_d   = 1'b0;
                end
            endcase
        end

        // Present the first bit of a packet and flag it with the strobe.
        if (launch) begin
            strobe_d = 1'b1;
            tmr_load = 1'b1;
`ifdef WU_TX_MANCHESTER_EN
            half_d   = 1'b0;
`endif
            if (sel_pre != 8'd0) begin
                state_d = PREAMBLE;
                idx_d   = 8'd0;
                mod_d   = 1'b1;
                tmr_val = sel_bp - CNT_W'(1);
            end else begin
                state_d = PAYLOAD;
                idx_d   = sel_len - 8'd1;
                mod_d   = sel_sig[idx_d[IDX_W-1:0]];
                tmr_val = sym_reload(sel_bp);
            end
        end
    end

    // State, output and shadow registers.
    always_ff @(posedge clki or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            idx_q    <= 8'd0;
            mod_q    <= 1'b0;
            strobe_q <= 1'b0;
            done_q   <= 1'b0;
            pkts_q   <= 16'd0;
            sig_q    <= '0;
            len_q    <= 8'd0;
            bp_q     <= '0;
            pre_q    <= 8'd0;
            gap_q    <= '0;
            reps_q   <= 16'd0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            mod_q    <= mod_d;
            strobe_q <= strobe_d;
            done_q   <= done_d;
            pkts_q   <= pkts_d;
            sig_q    <= sig_d;
            len_q    <= len_d;
            bp_q     <= bp_d;
            pre_q    <= pre_d;
            gap_q    <= gap_d;
            reps_q   <= reps_d;
        end
    end

`ifdef WU_TX_MANCHESTER_EN
    // Half-bit phase register.
    always_ff @(posedge clki or negedge reset_n) begin
        if (!reset_n) begin
            half_q <= 1'b0;
        end else begin
            half_q <= half_d;
        end
    end
`endif

    // One timer serves bit, half-bit and gap timing.
    wu_bit_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clki       (clki),
        .reset_n    (reset_n),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .tick_o     (tmr_tick)
    );

    assign mod_out    = mod_q;
    assign pkt_strobe = strobe_q;
    assign busy       = (state_q != IDLE);
    assign done       = done_q;
    assign pkts_sent  = pkts_q;

endmodule

// File: tb/tb_wu_pkt_tx.sv
// Scoreboard bench for wu_pkt_tx: a reference model turns each request into a per-cycle expected trace.
// Latency: expectations start one cycle after the start sample edge.
// Backpressure: stimulus waits for the scoreboard to drain before issuing the next request.
module tb_wu_pkt_tx;

    logic        clki = 1'b0;
    logic        reset_n;
    logic        start;
    logic        abort;
    logic [31:0] signature;
    logic [5:0]  sig_len;
    logic [31:0] bit_period;
    logic [7:0]  preamble_len;
    logic [31:0] gap;
    logic [15:0] repeats;
    logic        mod_out;
    logic        pkt_strobe;
    logic        busy;
    logic        done;
    logic [15:0] pkts_sent;

    always #5 clki = ~clki;

    wu_pkt_tx dut (
        .clki         (clki),
        .reset_n      (reset_n),
        .start        (start),
        .abort        (abort),
        .signature    (signature),
        .sig_len      (sig_len),
        .bit_period   (bit_period),
        .preamble_len (preamble_len),
        .gap          (gap),
        .repeats      (repeats),
        .mod_out      (mod_out),
        .pkt_strobe   (pkt_strobe),
        .busy         (busy),
        .done         (done),
        .pkts_sent    (pkts_sent)
    );

`ifdef WU_TX_MANCHESTER_EN
    localparam bit MANCH = 1'b1;
`else
    localparam bit MANCH = 1'b0;
`endif

    typedef struct packed {
        logic        mod;
        logic        stb;
        logic        bsy;
        logic        dn;
        logic [15:0] pkts;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        trace_q[$];
    int          n_checks  = 0;
    int          n_fail    = 0;
    int          req_id    = 0;
    logic [15:0] last_pkts = 16'd0;

    function automatic exp_t mk(input logic m, input logic s, input logic b, input logic d,
                                input logic [15:0] pk);
        exp_t e;
        e.mod  = m;
        e.stb  = s;
        e.bsy  = b;
        e.dn   = d;
        e.pkts = pk;
        return e;
    endfunction

    // Reference model: per-cycle output trace for one request, from cycle 1 to the done cycle.
    task automatic gen_trace(input logic [31:0] s, input int l_in, input int b_in, input int p_in,
                             input int g_in, input int r_in);
        int b;
        int l;
        int r;
        bit lv[$];
        b = b_in;
        if (MANCH) b = b - (b % 2);
        if (b < 2) b = 2;
        l = (l_in == 0) ? 1 : ((l_in > 32) ? 32 : l_in);
        r = (r_in == 0) ? 1 : r_in;
        lv = {};
        for (int k = 0; k < p_in; k++)
            for (int c = 0; c < b; c++) lv.push_back((k % 2) == 0);
        for (int j = l - 1; j >= 0; j--) begin
            if (MANCH) begin
                for (int c = 0; c < b / 2; c++) lv.push_back(s[j]);
                for (int c = 0; c < b / 2; c++) lv.push_back(!s[j]);
            end else begin
                for (int c = 0; c < b; c++) lv.push_back(s[j]);
            end
        end
        trace_q = {};
        for (int p = 0; p < r; p++) begin
            if (p > 0)
                for (int c = 0; c < g_in; c++) trace_q.push_back(mk(1'b0, 1'b0, 1'b1, 1'b0, 16'(p)));
            for (int c = 0; c < lv.size(); c++)
                trace_q.push_back(mk(lv[c], (c == 0), 1'b1, 1'b0, 16'(p)));
        end
        trace_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b1, 16'(r)));
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, got, want);
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() > 0 && n < 5000) begin
            @(posedge clki);
            n++;
        end
        if (exp_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain req=%0d: %0d expected cycles still pending, expected 0", req_id, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic scramble();
        signature    = $urandom;
        sig_len      = 6'($urandom_range(0, 63));
        bit_period   = $urandom;
        preamble_len = 8'($urandom_range(0, 255));
        gap          = $urandom;
        repeats      = 16'($urandom_range(0, 65535));
    endtask

    // Issue one request; ab = 0 none, ab > 0 abort in that cycle, ab < 0 maybe a random abort.
    task automatic do_req(input logic [31:0] s, input int l, input int b, input int p, input int g,
                          input int r, input int ab);
        int a;
        gen_trace(s, l, b, p, g, r);
        a = ab;
        if (a < 0) begin
            a = 0;
            if (trace_q.size() > 6 && $urandom_range(0, 3) == 0)
                a = $urandom_range(4, trace_q.size() - 1);
        end
        req_id++;
        @(negedge clki);
        signature    = s;
        sig_len      = 6'(l);
        bit_period   = 32'(b);
        preamble_len = 8'(p);
        gap          = 32'(g);
        repeats      = 16'(r);
        start        = 1'b1;
        if (a == 0) begin
            foreach (trace_q[i]) exp_q.push_back(trace_q[i]);
            last_pkts = trace_q[trace_q.size() - 1].pkts;
        end else begin
            for (int i = 0; i < a; i++) exp_q.push_back(trace_q[i]);
            last_pkts = trace_q[a - 1].pkts;
        end
        exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, last_pkts));
        exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, last_pkts));
        @(negedge clki);
        start = 1'b0;
        scramble();
        @(negedge clki);
        start = 1'b1;
        @(negedge clki);
        start = 1'b0;
        if (a > 0) begin
            repeat (a - 3) @(negedge clki);
            abort = 1'b1;
            @(negedge clki);
            abort = 1'b0;
        end
        wait_drain();
    endtask

    task automatic abort_start_idle();
        req_id++;
        @(negedge clki);
        start = 1'b1;
        abort = 1'b1;
        repeat (3) exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 1'b0, last_pkts));
        @(negedge clki);
        start = 1'b0;
        abort = 1'b0;
        wait_drain();
    endtask

    task automatic reset_mid();
        @(negedge clki);
        signature    = 32'hFF;
        sig_len      = 6'd8;
        bit_period   = 32'd4;
        preamble_len = 8'd0;
        gap          = 32'd0;
        repeats      = 16'd2;
        start        = 1'b1;
        @(negedge clki);
        start = 1'b0;
        repeat (6) @(posedge clki);
        #2;
        chk("busy_before_rst", {31'd0, busy}, 32'd1);
        chk("mod_before_rst", {31'd0, mod_out}, 32'd1);
        #1 reset_n = 1'b0;
        #1;
        chk("rst_mid_mod", {31'd0, mod_out}, 32'd0);
        chk("rst_mid_stb", {31'd0, pkt_strobe}, 32'd0);
        chk("rst_mid_busy", {31'd0, busy}, 32'd0);
        chk("rst_mid_done", {31'd0, done}, 32'd0);
        chk("rst_mid_pkts", {16'd0, pkts_sent}, 32'd0);
        @(negedge clki);
        reset_n   = 1'b1;
        last_pkts = 16'd0;
    endtask

    // Monitor: one expected entry per cycle while the scoreboard holds entries.
    initial begin
        exp_t e;
        exp_t a;
        forever begin
            @(posedge clki);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                a = mk(mod_out, pkt_strobe, busy, done, pkts_sent);
                n_checks++;
                if (a !== e) begin
                    n_fail++;
                    $display("FAIL trace req=%0d: got mod=%b stb=%b busy=%b done=%b pkts=%0d, expected mod=%b stb=%b busy=%b done=%b pkts=%0d",
                             req_id, a.mod, a.stb, a.bsy, a.dn, a.pkts, e.mod, e.stb, e.bsy, e.dn, e.pkts);
                end
            end
        end
    end

    initial begin
        #2000000;
        n_fail++;
        $display("FAIL watchdog: simulation still running at time %0t, expected to have finished", $time);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n      = 1'b0;
        start        = 1'b0;
        abort        = 1'b0;
        signature    = 32'd0;
        sig_len      = 6'd0;
        bit_period   = 32'd0;
        preamble_len = 8'd0;
        gap          = 32'd0;
        repeats      = 16'd0;
        repeat (2) @(negedge clki);
        chk("rst_mod", {31'd0, mod_out}, 32'd0);
        chk("rst_stb", {31'd0, pkt_strobe}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_pkts", {16'd0, pkts_sent}, 32'd0);
        reset_n = 1'b1;

        do_req(32'hA5, 8, 4, 0, 0, 1, 0);          // basic packet
        do_req(32'hF, 4, 2, 4, 10, 3, 0);          // preamble, gap, repeats
        do_req(32'h1, 0, 0, 0, 3, 0, 0);           // all clamps
        do_req(32'hA5, 8, 4, 0, 0, 1, 10);         // abort mid-payload
        do_req(32'hA5, 8, 4, 0, 0, 1, 0);          // normal run after abort
        abort_start_idle();
        reset_mid();
        do_req(32'h1, 1, 5, 0, 0, 1, 0);           // odd bit period
        do_req(32'hFFFF_0001, 50, 2, 1, 0, 2, 0);  // sig_len above maximum, back-to-back packets
        do_req(32'h8000_0001, 32, 3, 3, 1, 2, 0);  // full-length signature, 1-cycle gap

        for (int i = 0; i < 25; i++) begin
            do_req($urandom, $urandom_range(0, 36), $urandom_range(0, 5), $urandom_range(0, 4),
                   $urandom_range(0, 5), $urandom_range(0, 3), -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
